fde_sequencer: RTL and testbench
================================

Name: fde_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback control sequencer. It replaces the opcode-combinational control unit with a registered FSM. It drives the register file, ALU, memory and PC, evaluates branch conditions from flags, and waits on a memory request/acknowledge handshake. It sits between the instruction register/flags and the datapath.

Parameters:
OP_W, 4, opcode width; opcodes >= 16 are illegal
ALU_W, 4, alu_func width; the low 4 bits carry the opcode and the upper bits are zero
MEM_TIMEOUT, 15, maximum wait cycles for mem_ack (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  run enable; low freezes the sequencer
op  input  OP_W  opcode from the instruction register, valid in DECODE
immed_in  input  1  immediate-operand flag from the instruction
flag_z  input  1  zero flag
flag_n  input  1  negative flag
mem_ack  input  1  memory transaction complete
mem_req  output  1  memory transaction request
mem_sel  output  1  address source: 0 = PC, 1 = ALU result
read_write  output  1  1 = read, 0 = write
ir_load  output  1  one-cycle strobe that loads the instruction register
w_en  output  1  one-cycle register-file write strobe
alu_func  output  ALU_W  ALU operation
immed_sel  output  1  registered copy of immed_in
flag_en  output  1  one-cycle flag-update strobe
pc_inc  output  1  one-cycle strobe: PC <= PC+1
pc_load  output  1  one-cycle strobe: PC <= branch target
retire  output  1  one-cycle strobe: instruction completed
illegal_op  output  1  one-cycle strobe: illegal opcode decoded
state  output  3  current state encoding
fault  output  1  sticky memory-timeout fault (optional feature)

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH (0). All outputs 0, including alu_func=0 and fault=0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- FETCH: mem_req=1, mem_sel=0, read_write=1. On mem_ack: ir_load=1 for that cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Latch op and immed_in into internal registers; immed_sel follows the latched value.
  - Evaluate taken: JMP(0) always; BNE(D) if !flag_z; BLT(E) if flag_n; BE(F) if flag_z; all other opcodes not taken.
  - Illegal opcode (op >= 16 when OP_W > 4): illegal_op=1, then execute as NOP (no w_en, no flag_en, pc_inc in WB).
  - Go to EXEC.
- EXEC:
  - alu_func is driven from the latched opcode.
  - flag_en=1 for opcodes 1-4 and 8-C.
  - LD(5) or ST(6): go to MEM. All other opcodes: go to WB.
- MEM: mem_req=1, mem_sel=1, read_write=1 for LD and 0 for ST. On mem_ack go to WB; otherwise stay in MEM.
- WB:
  - w_en=1 for opcodes 1-5 and 7-C.
  - If taken: pc_load=1. Otherwise: pc_inc=1.
  - retire=1, then go to FETCH.
- Latency with mem_ack in the same cycle as mem_req:
  - Non-memory instruction: 4 cycles.
  - LD/ST: 5 cycles.
  - Each cycle without ack adds 1 cycle.
- Handshake:
  - mem_ack is ignored when mem_req=0.
  - mem_req stays asserted and its address/direction outputs stay stable until ack arrives.
  - mem_req drops in the cycle after ack.
- en=0:
  - The FSM holds its state and the latched registers.
  - All strobes (ir_load, w_en, flag_en, pc_inc, pc_load, retire, illegal_op) are forced to 0.
  - mem_req, mem_sel and read_write hold their values; an in-flight request is never withdrawn.
  - A mem_ack arriving while en=0 is captured in ack_pending and consumed on the first cycle with en=1.
- Strobes are mutually exclusive in time except for the WB set (w_en, pc_inc/pc_load, retire).
- Reset asserted mid-instruction aborts immediately with no strobes. After reset is released, the sequencer restarts in FETCH.

Optional Feature:
CTRL_MEM_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 and mem_ack=0 (frozen while en=0).
  - When the counter reaches MEM_TIMEOUT, the sequencer enters FAULT: fault=1 (sticky), mem_req=0, no strobes.
  - FAULT is left only by reset.
- Not defined: no counter and no FAULT state; fault is tied to 0; the sequencer waits indefinitely.

Test Plan:
- ADDS (op=1) with ack every request -> 4 cycles; flag_en in cycle 3, then w_en, pc_inc and retire together in cycle 4; alu_func=4'b0001.
- LD (op=5) with ack delayed 3 cycles in MEM -> mem_sel=1, read_write=1 held for 4 cycles; retire in cycle 8.
- BE (op=F): flag_z=1 -> pc_load=1, pc_inc=0. flag_z=0 -> pc_inc=1. BLT (op=E) with flag_n=1 -> pc_load=1.
- ST (op=6) with en dropped for 5 cycles during MEM and ack pulsed during the freeze -> state held at 3, no strobes, WB on the first en=1 cycle, w_en=0.
- Reset pulsed low during EXEC -> all outputs 0 immediately; state=0 after release; mem_req=1 on the next clock.
- With CTRL_MEM_TIMEOUT_EN and MEM_TIMEOUT=15, no ack in FETCH -> fault=1 after 15 wait cycles, state=5, mem_req=0 until reset.

Source files
------------

// File: rtl/fde_sequencer.sv
// fde_sequencer
//   Multi-cycle fetch/decode/execute/writeback control sequencer. A registered
//   FSM walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB
//   and drives the register file, ALU, memory and PC control lines. Memory
//   accesses use a req/ack handshake. The request is held until ack arrives.
//
//   Optional feature macro: CTRL_MEM_TIMEOUT_EN
//     When defined, a wait counter tracks cycles spent waiting for mem_ack.
//     After MEM_TIMEOUT wait cycles the sequencer parks in a sticky FAULT
//     state that only reset can leave. When undefined, there is no FAULT
//     state and fault is tied low.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   en          run enable; low freezes state and forces all strobes to 0
//   op          opcode from the instruction register (sampled in DECODE)
//   immed_in    immediate-operand flag from the instruction
//   flag_z      zero flag
//   flag_n      negative flag
//   mem_ack     memory transaction complete
//   mem_req     memory transaction request
//   mem_sel     memory address source: 0 = PC, 1 = ALU result
//   read_write  1 = read, 0 = write
//   ir_load     strobe that loads the instruction register
//   w_en        register-file write strobe
//   alu_func    ALU operation (latched opcode, zero-extended)
//   immed_sel   registered copy of immed_in
//   flag_en     flag-update strobe
//   pc_inc      PC <= PC + 1 strobe
//   pc_load     PC <= branch target strobe
//   retire      instruction-complete strobe
//   illegal_op  illegal-opcode strobe (raised in DECODE)
//   state       current state encoding
//   fault       sticky memory-timeout fault
module fde_sequencer #(
  parameter int OP_W        = 4,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             immed_in,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             read_write,
  output logic             ir_load,
  output logic             w_en,
  output logic [ALU_W-1:0] alu_func,
  output logic             immed_sel,
  output logic             flag_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             retire,
  output logic             illegal_op,
  output logic [2:0]       state,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BNE = 4'hD;
  localparam logic [3:0] OP_BLT = 4'hE;
  localparam logic [3:0] OP_BE  = 4'hF;

  state_t     cur_state;
  state_t     nxt_state;

  // started holds outputs low after reset release until the first enabled
  // clock, so every output reads 0 while reset is asserted and mem_req only
  // rises one clock after release.
  logic       started;
  logic       active;
  logic       req_phase;
  logic       ack_pending;
  logic       ack_eff;

  logic [3:0] code_q;
  logic       illegal_q;
  logic       immed_q;
  logic       taken_q;

  logic       op_illegal;
  logic       op_taken;
  logic       code_flags;
  logic       code_writes;
  logic       code_mem;

  assign active    = started & en;
  assign req_phase = started & ((cur_state == S_FETCH) | (cur_state == S_MEM));
  assign ack_eff   = mem_ack | ack_pending;

  // Opcodes wider than 4 bits are illegal whenever any upper bit is set.
  generate
    if (OP_W > 4) begin : g_wide_op
      assign op_illegal = |op[OP_W-1:4];
    end else begin : g_narrow_op
      assign op_illegal = 1'b0;
    end
  endgenerate

  // Branch condition, evaluated against the flags present during DECODE.
  always_comb begin
    op_taken = 1'b0;
    case (op[3:0])
      OP_JMP:  op_taken = 1'b1;
      OP_BNE:  op_taken = !flag_z;
      OP_BLT:  op_taken = flag_n;
      OP_BE:   op_taken = flag_z;
      default: op_taken = 1'b0;
    endcase
    if (op_illegal) op_taken = 1'b0;
  end

  // Class decode of the latched opcode. An illegal opcode behaves as a NOP.
  assign code_flags  = !illegal_q &&
                       (((code_q >= 4'h1) && (code_q <= 4'h4)) ||
                        ((code_q >= 4'h8) && (code_q <= 4'hC)));
  assign code_writes = !illegal_q &&
                       (((code_q >= 4'h1) && (code_q <= 4'h5)) ||
                        ((code_q >= 4'h7) && (code_q <= 4'hC)));
  assign code_mem    = !illegal_q && ((code_q == OP_LD) || (code_q == OP_ST));

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Wait counter: cleared whenever the FSM changes state (so on every entry
  // to FETCH or MEM), counts enabled cycles spent waiting for an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (active) begin
      if (nxt_state != cur_state) begin
        wait_cnt <= '0;
      end else if (req_phase && !ack_eff) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign fault = (cur_state == S_FAULT);
`else
  logic unused_timeout;
  assign unused_timeout = (MEM_TIMEOUT != 0);
  assign fault          = 1'b0;
`endif

  // State register plus the decode-time latches. An ack seen while frozen
  // is parked in ack_pending and consumed on the next enabled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= S_FETCH;
      started     <= 1'b0;
      ack_pending <= 1'b0;
      code_q      <= 4'h0;
      illegal_q   <= 1'b0;
      immed_q     <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      if (en) started <= 1'b1;

      if (!en) begin
        if (req_phase && mem_ack) ack_pending <= 1'b1;
      end else begin
        ack_pending <= 1'b0;
      end

      if (active) cur_state <= nxt_state;

      if (active && (cur_state == S_DECODE)) begin
        code_q    <= op[3:0];
        illegal_q <= op_illegal;
        immed_q   <= immed_in;
        taken_q   <= op_taken;
      end
    end
  end

  // Memory interface is a pure function of state and the latched opcode, so
  // it stays stable across a freeze and is never withdrawn mid-request.
  assign mem_req    = req_phase;
  assign mem_sel    = started && (cur_state == S_MEM);
  assign read_write = started && ((cur_state == S_FETCH) ||
                                  ((cur_state == S_MEM) && (code_q == OP_LD)));
  assign immed_sel  = immed_q;
  assign state      = cur_state;

  // Next-state and strobe logic. Strobes only fire on enabled cycles.
  always_comb begin
    nxt_state  = cur_state;
    ir_load    = 1'b0;
    w_en       = 1'b0;
    flag_en    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    alu_func   = '0;

    if (started && (cur_state == S_EXEC) && !illegal_q) begin
      alu_func = ALU_W'(code_q);
    end

    if (active) begin
      case (cur_state)
        S_FETCH: begin
          if (ack_eff) begin
            ir_load   = 1'b1;
            nxt_state = S_DECODE;
          end
`ifdef CTRL_MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            nxt_state = S_FAULT;
          end
`endif
        end
        S_DECODE: begin
          illegal_op = op_illegal;
          nxt_state  = S_EXEC;
        end
        S_EXEC: begin
          flag_en   = code_flags;
          nxt_state = code_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (ack_eff) begin
            nxt_state = S_WB;
          end
`ifdef CTRL_MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            nxt_state = S_FAULT;
          end
`endif
        end
        S_WB: begin
          w_en      = code_writes;
          pc_load   = taken_q;
          pc_inc    = !taken_q;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end
        S_FAULT: begin
          nxt_state = S_FAULT;
        end
        default: begin
          nxt_state = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fde_sequencer.sv
// tb_fde_sequencer
//   Directed testbench for fde_sequencer. Inputs change just after each
//   falling edge and outputs are sampled 1 time unit later, half a period
//   away from the rising edge. The DUT is built with a 5-bit opcode so the
//   illegal-opcode path is reachable.
module tb_fde_sequencer;

  localparam int OP_W  = 5;
  localparam int ALU_W = 4;

  // Strobe vector bit positions: {ir_load, flag_en, w_en, pc_inc, pc_load, retire, illegal_op}
  localparam logic [6:0] ST_NONE = 7'b0000000;
  localparam logic [6:0] ST_IR   = 7'b1000000;
  localparam logic [6:0] ST_FLAG = 7'b0100000;
  localparam logic [6:0] ST_WEN  = 7'b0010000;
  localparam logic [6:0] ST_INC  = 7'b0001000;
  localparam logic [6:0] ST_LOAD = 7'b0000100;
  localparam logic [6:0] ST_RET  = 7'b0000010;
  localparam logic [6:0] ST_ILL  = 7'b0000001;

  // Branch / writeback table: opcode, flag_z, flag_n, expected WB strobes
  localparam logic [4:0] BR_OP [6] = '{5'h0F, 5'h0F, 5'h0E, 5'h0D, 5'h00, 5'h07};
  localparam logic       BR_Z  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic       BR_N  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [6:0] BR_WB [6] = '{ST_LOAD | ST_RET,
                                       ST_INC  | ST_RET,
                                       ST_LOAD | ST_RET,
                                       ST_INC  | ST_RET,
                                       ST_LOAD | ST_RET,
                                       ST_WEN  | ST_INC | ST_RET};

  logic             clk;
  logic             reset;
  logic             en;
  logic [OP_W-1:0]  op;
  logic             immed_in;
  logic             flag_z;
  logic             flag_n;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_sel;
  logic             read_write;
  logic             ir_load;
  logic             w_en;
  logic [ALU_W-1:0] alu_func;
  logic             immed_sel;
  logic             flag_en;
  logic             pc_inc;
  logic             pc_load;
  logic             retire;
  logic             illegal_op;
  logic [2:0]       state;
  logic             fault;

  logic [6:0] strobes;
  logic [2:0] mem_if;

  int checks;
  int errors;

  assign strobes = {ir_load, flag_en, w_en, pc_inc, pc_load, retire, illegal_op};
  assign mem_if  = {mem_req, mem_sel, read_write};

  fde_sequencer #(
    .OP_W       (OP_W),
    .ALU_W      (ALU_W),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .op        (op),
    .immed_in  (immed_in),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .read_write(read_write),
    .ir_load   (ir_load),
    .w_en      (w_en),
    .alu_func  (alu_func),
    .immed_sel (immed_sel),
    .flag_en   (flag_en),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .retire    (retire),
    .illegal_op(illegal_op),
    .state     (state),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walks one non-memory instruction from FETCH to the WB cycle and stops
  // just after sampling time in WB. Starts from a FETCH cycle.
  task automatic drive_to_wb(input logic [4:0] opc, input logic z, input logic n);
    @(negedge clk); op = opc; flag_z = z; flag_n = n; mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL rst_state got %0d want %0d", state, 3'd0); end
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL rst_strobes got %b want %b", strobes, ST_NONE); end
    checks++; if (mem_if !== 3'b000) begin errors++; $display("[TB] FAIL rst_mem_if got %b want %b", mem_if, 3'b000); end
    checks++; if (alu_func !== 4'h0) begin errors++; $display("[TB] FAIL rst_alu_func got %h want %h", alu_func, 4'h0); end
    checks++; if (immed_sel !== 1'b0) begin errors++; $display("[TB] FAIL rst_immed_sel got %b want %b", immed_sel, 1'b0); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault got %b want %b", fault, 1'b0); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (mem_if !== 3'b000) begin errors++; $display("[TB] FAIL rel_mem_if got %b want %b", mem_if, 3'b000); end
    @(negedge clk); #1;
    checks++; if (mem_if !== 3'b101) begin errors++; $display("[TB] FAIL fetch_mem_if got %b want %b", mem_if, 3'b101); end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL fetch_state got %0d want %0d", state, 3'd0); end
  endtask

  task automatic test_adds();
    @(negedge clk); op = 5'h01; immed_in = 1'b1; mem_ack = 1'b1; #1;
    checks++; if (strobes !== ST_IR) begin errors++; $display("[TB] FAIL adds_c1_strobes got %b want %b", strobes, ST_IR); end
    checks++; if (mem_if !== 3'b101) begin errors++; $display("[TB] FAIL adds_c1_mem_if got %b want %b", mem_if, 3'b101); end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL adds_c2_state got %0d want %0d", state, 3'd1); end
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL adds_c2_strobes got %b want %b", strobes, ST_NONE); end
    checks++; if (mem_if !== 3'b000) begin errors++; $display("[TB] FAIL adds_c2_mem_if got %b want %b", mem_if, 3'b000); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL adds_c3_state got %0d want %0d", state, 3'd2); end
    checks++; if (strobes !== ST_FLAG) begin errors++; $display("[TB] FAIL adds_c3_strobes got %b want %b", strobes, ST_FLAG); end
    checks++; if (alu_func !== 4'b0001) begin errors++; $display("[TB] FAIL adds_alu_func got %b want %b", alu_func, 4'b0001); end
    checks++; if (immed_sel !== 1'b1) begin errors++; $display("[TB] FAIL adds_immed_sel got %b want %b", immed_sel, 1'b1); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL adds_c4_state got %0d want %0d", state, 3'd4); end
    checks++; if (strobes !== (ST_WEN | ST_INC | ST_RET)) begin errors++; $display("[TB] FAIL adds_c4_strobes got %b want %b", strobes, ST_WEN | ST_INC | ST_RET); end
    @(negedge clk); #1;
    checks++; if (mem_if !== 3'b101) begin errors++; $display("[TB] FAIL adds_next_fetch got %b want %b", mem_if, 3'b101); end
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL adds_next_strobes got %b want %b", strobes, ST_NONE); end
  endtask

  task automatic test_ld_wait();
    @(negedge clk); op = 5'h05; immed_in = 1'b0; mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if (alu_func !== 4'h5) begin errors++; $display("[TB] FAIL ld_alu_func got %h want %h", alu_func, 4'h5); end
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL ld_exec_strobes got %b want %b", strobes, ST_NONE); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = (i == 3); #1;
      checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL ld_mem%0d_state got %0d want %0d", i, state, 3'd3); end
      checks++; if (mem_if !== 3'b111) begin errors++; $display("[TB] FAIL ld_mem%0d_mem_if got %b want %b", i, mem_if, 3'b111); end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL ld_c8_state got %0d want %0d", state, 3'd4); end
    checks++; if (strobes !== (ST_WEN | ST_INC | ST_RET)) begin errors++; $display("[TB] FAIL ld_c8_strobes got %b want %b", strobes, ST_WEN | ST_INC | ST_RET); end
    checks++; if (mem_if !== 3'b000) begin errors++; $display("[TB] FAIL ld_c8_mem_if got %b want %b", mem_if, 3'b000); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 6; i++) begin
      drive_to_wb(BR_OP[i], BR_Z[i], BR_N[i]);
      checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL br%0d_state got %0d want %0d", i, state, 3'd4); end
      checks++; if (strobes !== BR_WB[i]) begin errors++; $display("[TB] FAIL br%0d_strobes got %b want %b", i, strobes, BR_WB[i]); end
    end
    flag_z = 1'b0;
    flag_n = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clk); op = 5'h15; mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if (strobes !== ST_ILL) begin errors++; $display("[TB] FAIL ill_decode_strobes got %b want %b", strobes, ST_ILL); end
    @(negedge clk); #1;
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL ill_exec_strobes got %b want %b", strobes, ST_NONE); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL ill_wb_state got %0d want %0d", state, 3'd4); end
    checks++; if (strobes !== (ST_INC | ST_RET)) begin errors++; $display("[TB] FAIL ill_wb_strobes got %b want %b", strobes, ST_INC | ST_RET); end
  endtask

  task automatic test_st_freeze();
    @(negedge clk); op = 5'h06; mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL st_mem_state got %0d want %0d", state, 3'd3); end
    checks++; if (mem_if !== 3'b110) begin errors++; $display("[TB] FAIL st_mem_if got %b want %b", mem_if, 3'b110); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); en = 1'b0; mem_ack = (i == 1); #1;
      checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL st_frz%0d_state got %0d want %0d", i, state, 3'd3); end
      checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL st_frz%0d_strobes got %b want %b", i, strobes, ST_NONE); end
      checks++; if (mem_if !== 3'b110) begin errors++; $display("[TB] FAIL st_frz%0d_mem_if got %b want %b", i, mem_if, 3'b110); end
    end
    @(negedge clk); en = 1'b1; mem_ack = 1'b0; #1;
    checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL st_resume_state got %0d want %0d", state, 3'd3); end
    @(negedge clk); #1;
    checks++; if (state !== 3'd4) begin errors++; $display("[TB] FAIL st_wb_state got %0d want %0d", state, 3'd4); end
    checks++; if (strobes !== (ST_INC | ST_RET)) begin errors++; $display("[TB] FAIL st_wb_strobes got %b want %b", strobes, ST_INC | ST_RET); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); op = 5'h01; immed_in = 1'b1; mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if (strobes !== ST_FLAG) begin errors++; $display("[TB] FAIL mid_exec_strobes got %b want %b", strobes, ST_FLAG); end
    #2 reset = 1'b0; #1;
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_state got %0d want %0d", state, 3'd0); end
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL mid_rst_strobes got %b want %b", strobes, ST_NONE); end
    checks++; if (mem_if !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_mem_if got %b want %b", mem_if, 3'b000); end
    checks++; if (alu_func !== 4'h0) begin errors++; $display("[TB] FAIL mid_rst_alu_func got %h want %h", alu_func, 4'h0); end
    checks++; if (immed_sel !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_immed_sel got %b want %b", immed_sel, 1'b0); end
    @(negedge clk); reset = 1'b1; immed_in = 1'b0; #1;
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL mid_rel_state got %0d want %0d", state, 3'd0); end
    @(negedge clk); #1;
    checks++; if (mem_if !== 3'b101) begin errors++; $display("[TB] FAIL mid_restart_mem_if got %b want %b", mem_if, 3'b101); end
  endtask

`ifdef CTRL_MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk); reset = 1'b0; mem_ack = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL to_wait%0d_state got %0d want %0d", i, state, 3'd0); end
    end
    @(negedge clk); #1;
    checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL to_state got %0d want %0d", state, 3'd5); end
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL to_fault got %b want %b", fault, 1'b1); end
    checks++; if (mem_if[2] !== 1'b0) begin errors++; $display("[TB] FAIL to_mem_req got %b want %b", mem_if[2], 1'b0); end
    @(negedge clk); mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL to_sticky_state got %0d want %0d", state, 3'd5); end
    checks++; if (strobes !== ST_NONE) begin errors++; $display("[TB] FAIL to_sticky_strobes got %b want %b", strobes, ST_NONE); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL to_clear_fault got %b want %b", fault, 1'b0); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    en       = 1'b1;
    op       = '0;
    immed_in = 1'b0;
    flag_z   = 1'b0;
    flag_n   = 1'b0;
    mem_ack  = 1'b0;

    test_reset();
    test_adds();
    test_ld_wait();
    test_branch();
    test_illegal();
    test_st_freeze();
    test_reset_mid();
`ifdef CTRL_MEM_TIMEOUT_EN
    test_timeout();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
